imem_loader: RTL and testbench

Boot-time writer for the 64-word instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instructions, and issues one write per word into the writable instruction RAM. The RAM feeds the CPU fetch port. While loading, the block holds the CPU in reset. The stream is framed by a word-count header and closed by an XOR checksum byte.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_word_assembler.sv | 35 +++
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

    // Instruction RAM geometry, also used for the RAM itself and the PC width.
    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and flags the
// 4th byte of each word. The completed word is presented combinationally
// alongside the strobe so the caller can register it in the same edge.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_done
);

    // Only the three older bytes need storage; the 4th arrives on data.
    logic [23:0] sh;
    logic [1:0]  cnt;

    assign word      = {sh, data};
    assign word_done = en && (cnt == 2'd3);

    // Shift register and wrapping byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sh  <= '0;
            cnt <= '0;
        end else if (en) begin
            sh  <= {sh[15:0], data};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: header (word count), 4*N big-endian data bytes, XOR
// checksum trailer. Writes each word into instruction RAM and holds the CPU
// in reset while loading or after a failed load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] widx;      // index of the word being assembled
    logic [ADDR_W-1:0] last_idx;  // N-1, fits ADDR_W since N <= DEPTH
    logic [7:0]        acc;       // running XOR of data bytes
    logic              accept;
    logic              enter_hdr;
    logic              hdr_bad;
    logic [31:0]       word;
    logic              word_done;
    logic              in_ready_d, busy_d, done_d, err_d, hold_d;

    // in_ready is a registered copy of the state decode, so accept never
    // depends combinationally on anything but flops and in_valid.
    assign accept    = in_valid && in_ready;
    assign enter_hdr = start && (state_q == ST_IDLE || state_q == ST_DONE ||
                                 state_q == ST_ERR);
    assign hdr_bad   = (in_byte == 8'd0) || ({1'b0, in_byte} > DEPTH9);

    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (enter_hdr),
        .en        (accept && state_q == ST_DATA),
        .data      (in_byte),
        .word      (word),
        .word_done (word_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_HEADER;
            ST_HEADER: if (accept) state_d = hdr_bad ? ST_ERR : ST_DATA;
            ST_DATA:   if (word_done && widx == last_idx) state_d = ST_CHECK;
            ST_CHECK:  if (accept) state_d = (in_byte == acc) ? ST_DONE : ST_ERR;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state; registered below so every status
    // output lines up with the state it describes.
    always_comb begin
        in_ready_d = (state_d == ST_HEADER) || (state_d == ST_DATA) ||
                     (state_d == ST_CHECK);
        busy_d     = in_ready_d;
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        hold_d     = !((state_d == ST_IDLE) || (state_d == ST_DONE));
    end

    // Status output registers; cpu_hold is asserted while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            in_ready <= in_ready_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            cpu_hold <= hold_d;
        end
    end

    // Datapath: word count, checksum and the one-cycle RAM write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx     <= '0;
            last_idx <= '0;
            acc      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= word_done;
            if (enter_hdr) begin
                widx <= '0;
                acc  <= '0;
            end
            if (state_q == ST_HEADER && accept)
                last_idx <= ADDR_W'(in_byte - 8'd1);
            if (state_q == ST_DATA && accept)
                acc <= acc ^ in_byte;
            if (word_done) begin
                wr_addr <= widx;
                wr_data <= word;
                widx    <= widx + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two-word load, bad checksum, bad headers,
// full gapped load, mid-frame reset and control corner cases.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [5:0]  log_addr[$];
    logic [31:0] log_data[$];

    imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Record every write pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_two_word(input logic [7:0] trailer);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_byte(8'h20, 0); send_byte(8'h07, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(trailer, 0);
    endtask

    function automatic logic [31:0] full_word(input int k);
        return {8'(k), 8'(k ^ 8'h5A), 8'hA5, 8'(255 - k)};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        #13;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
        checks++; if (wr_addr !== 6'd0) begin errors++; $display("FAIL reset wr_addr: got %h want 0", wr_addr); end
        checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset wr_data: got %h want 0", wr_data); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset busy/done/err: got %b want 000", {busy, done, err}); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset cpu_hold: got %b want 1", cpu_hold); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL idle cpu_hold: got %b want 0", cpu_hold); end
    endtask

    task automatic test_two_word;
        log_addr.delete(); log_data.delete();
        pulse_start;
        checks++; if ({busy, in_ready, cpu_hold} !== 3'b111) begin errors++; $display("FAIL two_word header state: got %b want 111", {busy, in_ready, cpu_hold}); end
        send_byte(8'h02, 0);
        send_byte(8'h20, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL two_word early wr_en: got %b want 0", wr_en); end
        send_byte(8'h05, 0);
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd0, 32'h20020005}) begin errors++; $display("FAIL two_word write0: got %b %h %h want 1 00 20020005", wr_en, wr_addr, wr_data); end
        send_byte(8'h20, 0);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL two_word pulse width: got %b want 0", wr_en); end
        send_byte(8'h07, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd1, 32'h20070003}) begin errors++; $display("FAIL two_word write1: got %b %h %h want 1 01 20070003", wr_en, wr_addr, wr_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL two_word check busy: got %b want 1", busy); end
        send_byte(8'h03, 0);
        checks++; if ({done, err, cpu_hold, busy, in_ready} !== 5'b10000) begin errors++; $display("FAIL two_word done: got done/err/hold/busy/rdy %b want 10000", {done, err, cpu_hold, busy, in_ready}); end
        checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL two_word write count: got %0d want 2", log_addr.size()); end
    endtask

    task automatic test_bad_checksum;
        log_addr.delete(); log_data.delete();
        pulse_start;
        checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL restart_from_done: got done/busy %b want 01", {done, busy}); end
        send_two_word(8'h04);
        checks++; if ({done, err, cpu_hold, busy} !== 4'b0110) begin errors++; $display("FAIL bad_csum flags: got done/err/hold/busy %b want 0110", {done, err, cpu_hold, busy}); end
        checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL bad_csum write count: got %0d want 2", log_addr.size()); end
        else begin
            checks++; if ({log_addr[1], log_data[1]} !== {6'd1, 32'h20070003}) begin errors++; $display("FAIL bad_csum last write: got %h %h want 01 20070003", log_addr[1], log_data[1]); end
        end
    endtask

    task automatic test_bad_header(input logic [7:0] hdr);
        log_addr.delete(); log_data.delete();
        pulse_start;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_header %h err cleared: got %b want 0", hdr, err); end
        send_byte(hdr, 0);
        checks++; if ({err, done, busy, in_ready, cpu_hold} !== 5'b10001) begin errors++; $display("FAIL bad_header %h flags: got err/done/busy/rdy/hold %b want 10001", hdr, {err, done, busy, in_ready, cpu_hold}); end
        send_byte(8'h20, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        @(posedge clk); #1;
        checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL bad_header %h writes: got %0d want 0", hdr, log_addr.size()); end
    endtask

    task automatic test_full_load;
        logic [7:0]  csum;
        logic [31:0] w;
        int          bad;
        log_addr.delete(); log_data.delete();
        csum = 8'h00;
        pulse_start;
        send_byte(8'h40, $urandom_range(0, 2));
        for (int k = 0; k < 64; k++) begin
            w = full_word(k);
            csum = csum ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            for (int b = 3; b >= 0; b--)
                send_byte(w[b*8 +: 8], $urandom_range(0, 2));
        end
        send_byte(csum, $urandom_range(0, 2));
        checks++; if ({done, err, cpu_hold} !== 3'b100) begin errors++; $display("FAIL full_load flags: got done/err/hold %b want 100", {done, err, cpu_hold}); end
        checks++; if (log_addr.size() !== 64) begin errors++; $display("FAIL full_load write count: got %0d want 64", log_addr.size()); end
        else begin
            bad = 0;
            for (int k = 0; k < 64; k++) begin
                checks++;
                if ({log_addr[k], log_data[k]} !== {6'(k), full_word(k)}) begin
                    errors++;
                    if (bad < 4) $display("FAIL full_load write %0d: got %h %h want %h %h", k, log_addr[k], log_data[k], 6'(k), full_word(k));
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        int n;
        log_addr.delete(); log_data.delete();
        pulse_start;
        send_byte(8'h02, 0);
        send_byte(8'h20, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_byte(8'h20, 0); send_byte(8'h07, 0);
        n = log_addr.size();
        in_valid = 1'b1; in_byte = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, wr_en, busy, done, err, cpu_hold} !== 6'b000001) begin errors++; $display("FAIL midframe reset outputs: got %b want 000001", {in_ready, wr_en, busy, done, err, cpu_hold}); end
        checks++; if ({wr_addr, wr_data} !== 38'd0) begin errors++; $display("FAIL midframe reset addr/data: got %h %h want 0 0", wr_addr, wr_data); end
        in_byte = 8'h03;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (log_addr.size() !== n) begin errors++; $display("FAIL midframe no write after reset: got %0d want %0d", log_addr.size(), n); end
        log_addr.delete(); log_data.delete();
        pulse_start;
        send_two_word(8'h03);
        checks++; if ({done, err, log_addr.size()} !== {2'b10, 32'd2}) begin errors++; $display("FAIL midframe reload: got done/err %b writes %0d want 10 2", {done, err}, log_addr.size()); end
    endtask

    task automatic test_start_in_data;
        log_addr.delete(); log_data.delete();
        pulse_start;
        send_byte(8'h02, 0);
        send_byte(8'h20, 0); send_byte(8'h02, 0);
        start = 1'b1;
        send_byte(8'h00, 0);
        start = 1'b0;
        send_byte(8'h05, 0);
        send_byte(8'h20, 0); send_byte(8'h07, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(8'h03, 0);
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL start_in_data flags: got done/err %b want 10", {done, err}); end
        checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL start_in_data writes: got %0d want 2", log_addr.size()); end
        else begin
            checks++; if (log_data[0] !== 32'h20020005) begin errors++; $display("FAIL start_in_data word0: got %h want 20020005", log_data[0]); end
        end
    endtask

    initial begin
        test_reset;
        test_two_word;
        test_bad_checksum;
        test_bad_header(8'h00);
        test_bad_header(8'h41);
        test_full_load;
        test_reset_midframe;
        test_start_in_data;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
